parking_sensor_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of the parking occupancy FSM. It synchronises and debounces the raw entry/exit loop detectors, captures the exit slot ID, and queues one pending event per direction. It then issues clean single-cycle `entry_sensor` / `exit_sensor` pulses with a hold-off gap so the FSM advances exactly one state per physical car event. Simultaneous events are arbitrated, and entries arriving while the FSM reports full are rejected.

---
 rtl/parking_sensor_conditioner.sv | 165 ++++++++++++++++
 tb/tb_parking_sensor_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_conditioner.sv
// Synchronises and debounces entry/exit loop detectors, queues one event per direction, and arbitrates them into spaced single-cycle pulses.
// Optional full-lot gating is enabled by defining PSC_FULL_GATE_EN.
module parking_sensor_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_raw,
  input  logic       exit_raw,
  input  logic [1:0] exit_slot_raw,
  input  logic       full_light,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       entry_rejected,
  output logic       overrun
);

  localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  // Channel index 0 is entry, 1 is exit.
  logic [1:0]      raw_s1_q, raw_s2_q;
  logic [1:0]      slot_s1_q, slot_s2_q;
  logic [1:0]      stable_q, stable_d, prev_q;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;
  logic [1:0]      rise, clr;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      slot_q, slot_d;
  logic            overrun_q, overrun_d;
  state_t          state_q, state_d;
  logic [3:0]      hold_q, hold_d;
  logic            sel_exit_q, sel_exit_d;
  logic            last_exit_q, last_exit_d;
  logic            ent_pulse_q, ent_pulse_d;
  logic            ext_pulse_q, ext_pulse_d;
  logic [1:0]      loc_q, loc_d;
  logic            rej_q, rej_d;
  logic            full_gate, pick_exit;

`ifdef PSC_FULL_GATE_EN
  assign full_gate = full_light;
`else
  logic unused_full;
  assign unused_full = full_light;
  assign full_gate   = 1'b0;
`endif

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw_s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = raw_s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  assign rise = stable_q & ~prev_q;

  // A set coinciding with the clear of the same flag is a fresh event, not an overrun.
  always_comb begin
    pend_d    = (pend_q & ~clr) | rise;
    overrun_d = overrun_q | (|(rise & pend_q & ~clr));
    slot_d    = slot_q;
    if (rise[1] && !(pend_q[1] && !clr[1])) slot_d = slot_s2_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    sel_exit_d  = sel_exit_q;
    last_exit_d = last_exit_q;
    clr         = 2'b00;
    ent_pulse_d = 1'b0;
    ext_pulse_d = 1'b0;
    loc_d       = loc_q;
    rej_d       = 1'b0;
    pick_exit   = pend_q[1];
    if (pend_q == 2'b11) pick_exit = full_gate | ~last_exit_q;
    case (state_q)
      IDLE: begin
        if (pend_q == 2'b01 && full_gate) begin
          clr[0] = 1'b1;
          rej_d  = 1'b1;
        end else if (pend_q != 2'b00) begin
          state_d     = ISSUE;
          sel_exit_d  = pick_exit;
          ent_pulse_d = ~pick_exit;
          ext_pulse_d = pick_exit;
          if (pick_exit) loc_d = slot_q;
        end
      end
      ISSUE: begin
        clr         = sel_exit_q ? 2'b10 : 2'b01;
        last_exit_d = sel_exit_q;
        // The IDLE cycle is the last of the HOLDOFF quiet cycles.
        if (HOLDOFF <= 1) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_q <= 4'd1) state_d = IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raw_s1_q    <= '0;
      raw_s2_q    <= '0;
      slot_s1_q   <= '0;
      slot_s2_q   <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      db_cnt_q    <= '0;
      pend_q      <= '0;
      slot_q      <= '0;
      overrun_q   <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= '0;
      sel_exit_q  <= 1'b0;
      last_exit_q <= 1'b1;
      ent_pulse_q <= 1'b0;
      ext_pulse_q <= 1'b0;
      loc_q       <= '0;
      rej_q       <= 1'b0;
    end else begin
      raw_s1_q    <= {exit_raw, entry_raw};
      raw_s2_q    <= raw_s1_q;
      slot_s1_q   <= exit_slot_raw;
      slot_s2_q   <= slot_s1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      db_cnt_q    <= db_cnt_d;
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      sel_exit_q  <= sel_exit_d;
      last_exit_q <= last_exit_d;
      ent_pulse_q <= ent_pulse_d;
      ext_pulse_q <= ext_pulse_d;
      loc_q       <= loc_d;
      rej_q       <= rej_d;
    end
  end

  assign entry_sensor   = ent_pulse_q;
  assign exit_sensor    = ext_pulse_q;
  assign exit_location  = loc_q;
  assign entry_rejected = rej_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Directed bench: a default-parameter instance plus a long-holdoff instance for the overrun scenario.
module tb_parking_sensor_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       entry_raw, exit_raw, full_light;
  logic [1:0] slot_raw;
  logic       entry_sensor, exit_sensor, entry_rejected, overrun;
  logic [1:0] exit_location;

  logic       entry2_raw, exit2_raw;
  logic [1:0] slot2_raw;
  logic       entry2_sensor, exit2_sensor, entry2_rejected, overrun2;
  logic [1:0] exit2_location;

  int total = 0;
  int bad   = 0;
  int ent_n, ext_n, rej_n, both_n, e2_n, x2_n;

  always #5 clk = ~clk;

  parking_sensor_conditioner #(.DB_CYCLES(4), .HOLDOFF(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .entry_raw(entry_raw), .exit_raw(exit_raw),
    .exit_slot_raw(slot_raw), .full_light(full_light), .entry_sensor(entry_sensor),
    .exit_sensor(exit_sensor), .exit_location(exit_location),
    .entry_rejected(entry_rejected), .overrun(overrun)
  );

  parking_sensor_conditioner #(.DB_CYCLES(4), .HOLDOFF(15)) u_ovr (
    .clk(clk), .reset_n(reset_n), .entry_raw(entry2_raw), .exit_raw(exit2_raw),
    .exit_slot_raw(slot2_raw), .full_light(1'b0), .entry_sensor(entry2_sensor),
    .exit_sensor(exit2_sensor), .exit_location(exit2_location),
    .entry_rejected(entry2_rejected), .overrun(overrun2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sampling and driving both happen on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (entry_sensor) ent_n++;
    if (exit_sensor) ext_n++;
    if (entry_rejected) rej_n++;
    if (entry_sensor && exit_sensor) both_n++;
    if (entry2_sensor) e2_n++;
    if (exit2_sensor) x2_n++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; entry_raw = 0; exit_raw = 0; full_light = 0; slot_raw = 2'b00;
    entry2_raw = 0; exit2_raw = 0; slot2_raw = 2'b00;
    ent_n = 0; ext_n = 0; rej_n = 0; both_n = 0; e2_n = 0; x2_n = 0;
    repeat (3) tick();
    chk("rst_entry", {7'd0, entry_sensor}, 8'd0);
    chk("rst_exit", {7'd0, exit_sensor}, 8'd0);
    chk("rst_loc", {6'd0, exit_location}, 8'd0);
    chk("rst_rej", {7'd0, entry_rejected}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    reset_n = 1'b1;

    // Single entry held high: pulse after the 8th edge, then nothing.
    entry_raw = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("A_early", {7'd0, entry_sensor}, 8'd0);
    end
    tick();
    chk("A_pulse", {7'd0, entry_sensor}, 8'd1);
    chk("A_noexit", {7'd0, exit_sensor}, 8'd0);
    tick();
    chk("A_width", {7'd0, entry_sensor}, 8'd0);
    ent_n = 0;
    repeat (20) tick();
    chk("A_held", 8'(ent_n), 8'd0);
    entry_raw = 0;
    repeat (12) tick();

    // Three-cycle glitch on exit is filtered.
    ext_n = 0;
    exit_raw = 1;
    repeat (3) tick();
    exit_raw = 0;
    repeat (15) tick();
    chk("B_glitch", 8'(ext_n), 8'd0);
    chk("B_ovr", {7'd0, overrun}, 8'd0);

    // Simultaneous entry + exit after reset: entry wins, exit three cycles later.
    do_reset();
    entry_raw = 1; exit_raw = 1; slot_raw = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("C_early", {6'd0, entry_sensor, exit_sensor}, 8'd0);
    end
    tick();
    chk("C_first", {6'd0, entry_sensor, exit_sensor}, 8'b10);
    tick();
    chk("C_gap1", {6'd0, entry_sensor, exit_sensor}, 8'b00);
    tick();
    chk("C_gap2", {6'd0, entry_sensor, exit_sensor}, 8'b00);
    tick();
    chk("C_second", {6'd0, entry_sensor, exit_sensor}, 8'b01);
    chk("C_loc", {6'd0, exit_location}, 8'd2);
    tick();
    chk("C_after", {6'd0, entry_sensor, exit_sensor}, 8'b00);
    chk("C_loc_hold", {6'd0, exit_location}, 8'd2);
    entry_raw = 0; exit_raw = 0;
    repeat (12) tick();

    // Both pending while full.
    do_reset();
    ent_n = 0; rej_n = 0;
    full_light = 1; entry_raw = 1; exit_raw = 1; slot_raw = 2'b01;
    repeat (7) tick();
`ifdef PSC_FULL_GATE_EN
    tick();
    chk("D_exit_first", {6'd0, entry_sensor, exit_sensor}, 8'b01);
    chk("D_loc", {6'd0, exit_location}, 8'd1);
    tick();
    tick();
    chk("D_norej_yet", {7'd0, entry_rejected}, 8'd0);
    tick();
    chk("D_rej", {7'd0, entry_rejected}, 8'd1);
    tick();
    chk("D_rej_width", {7'd0, entry_rejected}, 8'd0);
    repeat (10) tick();
    chk("D_no_entry", 8'(ent_n), 8'd0);
`else
    tick();
    chk("D_entry_first", {6'd0, entry_sensor, exit_sensor}, 8'b10);
    repeat (2) tick();
    tick();
    chk("D_exit_second", {6'd0, entry_sensor, exit_sensor}, 8'b01);
    chk("D_loc", {6'd0, exit_location}, 8'd1);
    repeat (10) tick();
    chk("D_no_rej", 8'(rej_n), 8'd0);
`endif
    full_light = 0; entry_raw = 0; exit_raw = 0;
    repeat (12) tick();

    // Reset during HOLD with exit pending; entry held through reset.
    do_reset();
    entry_raw = 1; exit_raw = 1; slot_raw = 2'b11;
    repeat (8) tick();
    chk("E_entry", {7'd0, entry_sensor}, 8'd1);
    tick();
    reset_n = 1'b0; exit_raw = 0;
    repeat (3) tick();
    chk("E_rst_outs", {3'd0, entry_sensor, exit_sensor, exit_location, entry_rejected}, 8'd0);
    chk("E_rst_ovr", {7'd0, overrun}, 8'd0);
    reset_n = 1'b1;
    ent_n = 0; ext_n = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("E_early", {7'd0, entry_sensor}, 8'd0);
    end
    tick();
    chk("E_fresh", {7'd0, entry_sensor}, 8'd1);
    repeat (15) tick();
    chk("E_no_exit", 8'(ext_n), 8'd0);
    chk("E_one_entry", 8'(ent_n), 8'd1);
    entry_raw = 0;
    repeat (12) tick();

    // Overrun: second exit event (slot 3) lands while slot-1 exit waits behind a long hold.
    do_reset();
    e2_n = 0; x2_n = 0;
    entry2_raw = 1; exit2_raw = 1; slot2_raw = 2'b01;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 6) exit2_raw = 0;
      if (e == 10) slot2_raw = 2'b11;
      if (e == 12) exit2_raw = 1;
      if (e == 8) chk("F_entry", {7'd0, entry2_sensor}, 8'd1);
      if (e == 18) chk("F_ovr_pre", {7'd0, overrun2}, 8'd0);
      if (e == 20) chk("F_ovr", {7'd0, overrun2}, 8'd1);
      if (e == 23) chk("F_exit_wait", {7'd0, exit2_sensor}, 8'd0);
      if (e == 24) begin
        chk("F_exit", {7'd0, exit2_sensor}, 8'd1);
        chk("F_loc", {6'd0, exit2_location}, 8'd1);
      end
    end
    chk("F_exit_count", 8'(x2_n), 8'd1);
    chk("F_entry_count", 8'(e2_n), 8'd1);
    chk("excl", 8'(both_n), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
